// File: rtl/prio_demux_pkg.sv
// Shared types for the priority demux: channel state, target encoding, drop count width.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package prio_demux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CH1  = 2'd1,
    CH2  = 2'd2,
    CH3  = 2'd3
  } target_t;

  localparam int DROP_CNT_W = 8;

  // Fixed priority c1 > c2 > c3; no enable set means the word has nowhere to go.
  function automatic target_t sel_target(input logic c1, input logic c2, input logic c3);
    target_t t;
    if (c1)      t = CH1;
    else if (c2) t = CH2;
    else if (c3) t = CH3;
    else         t = NONE;
    return t;
  endfunction

endpackage

// File: rtl/prio_demux_slot.sv
// One-entry channel holding register with EMPTY/FULL state.
// Latency: word loaded on i_load appears on o_dout/o_vld the next cycle.
// Backpressure: holds the word until i_ack; a load in the ack cycle replaces it with no bubble.
module prio_demux_slot
  import prio_demux_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_ack,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_vld
);

  chan_state_t  r_state;
  chan_state_t  w_state_nxt;
  logic [W-1:0] r_dat;

  // State register; reset discards any held word.
  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Next state: a load always wins (covers ack+load back-to-back); ack on EMPTY stays EMPTY.
  always_comb begin
    w_state_nxt = r_state;
    if (i_load)     w_state_nxt = FULL;
    else if (i_ack) w_state_nxt = EMPTY;
  end

  // Data register; keeps the last word after it is acknowledged.
  always_ff @(posedge clk) begin
    if (rst)         r_dat <= '0;
    else if (i_load) r_dat <= i_din;
  end

  // Outputs are straight from registers.
  always_comb begin
    o_vld  = (r_state == FULL);
    o_dout = r_dat;
  end

endmodule

// File: rtl/prio_demux_tx.sv
// Routes one source word per cycle to the highest-priority enabled channel (c1>c2>c3).
// Latency: one cycle from accept to channel valid; build with PRIO_DEMUX_TX_DROP_CNT_EN for drop_cnt.
// Backpressure: a_ready low only when the target channel is FULL and not acked this cycle.
module prio_demux_tx
  import prio_demux_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a_in,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic         c1,
  input  logic         c2,
  input  logic         c3,
  output logic [W-1:0] b1,
  output logic [W-1:0] b2,
  output logic [W-1:0] b3,
  output logic         v1,
  output logic         v2,
  output logic         v3,
  input  logic         k1,
  input  logic         k2,
  input  logic         k3
`ifdef PRIO_DEMUX_TX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  target_t w_target;
  logic    w_accept;
  logic    w_load1;
  logic    w_load2;
  logic    w_load3;

  // Target selection, ready and per-channel load strobes.
  always_comb begin
    w_target = sel_target(c1, c2, c3);
    case (w_target)
      CH1:     a_ready = !v1 || k1;
      CH2:     a_ready = !v2 || k2;
      CH3:     a_ready = !v3 || k3;
      default: a_ready = 1'b1;
    endcase
    w_accept = a_valid && a_ready;
    w_load1  = w_accept && (w_target == CH1);
    w_load2  = w_accept && (w_target == CH2);
    w_load3  = w_accept && (w_target == CH3);
  end

  prio_demux_slot #(.W(W)) u_slot1 (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load1),
    .i_ack  (k1),
    .i_din  (a_in),
    .o_dout (b1),
    .o_vld  (v1)
  );

  prio_demux_slot #(.W(W)) u_slot2 (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load2),
    .i_ack  (k2),
    .i_din  (a_in),
    .o_dout (b2),
    .o_vld  (v2)
  );

  prio_demux_slot #(.W(W)) u_slot3 (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load3),
    .i_ack  (k3),
    .i_din  (a_in),
    .o_dout (b3),
    .o_vld  (v3)
  );

`ifdef PRIO_DEMUX_TX_DROP_CNT_EN
  logic                  w_drop;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  // A word accepted with no enabled channel is discarded and counted.
  always_comb begin
    w_drop = w_accept && (w_target == NONE);
  end

  // Saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst)                          r_drop_cnt <= '0;
    else if (w_drop && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_prio_demux_tx.sv
// Self-checking bench for prio_demux_tx: per-channel scoreboard queues plus directed and random traffic.
// Latency: checks channel outputs one cycle after each driven cycle.
// Backpressure: a_ready predicted from the bench's own channel occupancy model.
module tb_prio_demux_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a_in;
  logic         a_valid;
  wire          a_ready;
  logic [3:1]   c;
  logic [3:1]   k;
  wire  [W-1:0] b1, b2, b3;
  wire          v1, v2, v3;
`ifdef PRIO_DEMUX_TX_DROP_CNT_EN
  wire  [7:0]   drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];
  logic [W-1:0] q3[$];
  logic [W-1:0] last_b [1:3];
  int           exp_drop;

  prio_demux_tx #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_in    (a_in),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .c1      (c[1]),
    .c2      (c[2]),
    .c3      (c[3]),
    .b1      (b1),
    .b2      (b2),
    .b3      (b3),
    .v1      (v1),
    .v2      (v2),
    .v3      (v3),
    .k1      (k[1]),
    .k2      (k[2]),
    .k3      (k[3])
`ifdef PRIO_DEMUX_TX_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int qsize(input int n);
    case (n)
      1:       return q1.size();
      2:       return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [W-1:0] obs_b(input int n);
    case (n)
      1:       return b1;
      2:       return b2;
      default: return b3;
    endcase
  endfunction

  function automatic logic obs_v(input int n);
    case (n)
      1:       return v1;
      2:       return v2;
      default: return v3;
    endcase
  endfunction

  task automatic sb_push(input int n, input logic [W-1:0] d);
    case (n)
      1:       q1.push_back(d);
      2:       q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endtask

  // Consumer takes the word: it must be the one the scoreboard expects.
  task automatic sb_pop_check(input int n);
    logic [W-1:0] e;
    case (n)
      1:       e = q1.pop_front();
      2:       e = q2.pop_front();
      default: e = q3.pop_front();
    endcase
    check_eq($sformatf("consume_b%0d", n), 32'(obs_b(n)), 32'(e));
  endtask

  // One clock cycle: drive at negedge, predict, then check outputs at the next negedge.
  task automatic cyc(input logic r, input logic av, input logic [W-1:0] d,
                     input logic [3:1] cc, input logic [3:1] kk);
    int   tgt;
    logic exp_rdy;
    rst     = r;
    a_valid = av;
    a_in    = d;
    c       = cc;
    k       = kk;
    #1;
    tgt = cc[1] ? 1 : (cc[2] ? 2 : (cc[3] ? 3 : 0));
    if (r) begin
      q1.delete();
      q2.delete();
      q3.delete();
      for (int n = 1; n <= 3; n++) last_b[n] = '0;
      exp_drop = 0;
    end else begin
      exp_rdy = (tgt == 0) ? 1'b1 : ((qsize(tgt) == 0) || kk[tgt]);
      check_eq("a_ready", 32'(a_ready), 32'(exp_rdy));
      for (int n = 1; n <= 3; n++)
        if (kk[n] && qsize(n) != 0) sb_pop_check(n);
      if (av && exp_rdy) begin
        if (tgt == 0) begin
          if (exp_drop < 255) exp_drop++;
        end else begin
          sb_push(tgt, d);
          last_b[tgt] = d;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int n = 1; n <= 3; n++) begin
      check_eq($sformatf("v%0d", n), 32'(obs_v(n)), 32'(qsize(n) != 0));
      check_eq($sformatf("b%0d", n), 32'(obs_b(n)), 32'(last_b[n]));
    end
`ifdef PRIO_DEMUX_TX_DROP_CNT_EN
    check_eq("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
`endif
  endtask

  initial begin
    exp_drop = 0;
    for (int n = 1; n <= 3; n++) last_b[n] = '0;

    // Reset state.
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 3'b000);
    cyc(1'b1, 1'b1, 8'hAA, 3'b111, 3'b111);

    // First word to channel 1 lands next cycle.
    cyc(1'b0, 1'b1, 8'h01, 3'b001, 3'b000);

    // Channel 1 full and unacked: source stalls for 5 cycles, then ack lets the next word in.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h55, 3'b001, 3'b000);
    cyc(1'b0, 1'b1, 8'h55, 3'b001, 3'b001);

    // Load channel 2 while channel 1 is acked, then ack 2 while loading 1.
    cyc(1'b0, 1'b1, 8'hA2, 3'b010, 3'b001);
    cyc(1'b0, 1'b1, 8'hC1, 3'b001, 3'b010);

    // Both c1 and c2 set: only channel 1 loads; then c1 drops and channel 2 takes a zero word.
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 3'b000);
    cyc(1'b0, 1'b1, 8'h01, 3'b011, 3'b000);
    cyc(1'b0, 1'b1, 8'h00, 3'b010, 3'b000);

    // Enables change while channels hold data: outputs must not move.
    cyc(1'b0, 1'b0, 8'hEE, 3'b111, 3'b000);
    cyc(1'b0, 1'b1, 8'h33, 3'b100, 3'b000);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'(8'h70 + i), 3'b000, 3'b000);

    // Reset with channels full, an offered word and acks all in the same cycle.
    cyc(1'b1, 1'b1, 8'h99, 3'b001, 3'b111);
    cyc(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);

    // No enables: 300 words all accepted and dropped; counter saturates.
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 8'(i), 3'b000, 3'b000);

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    // Drain.
    cyc(1'b0, 1'b0, 8'h00, 3'b000, 3'b111);
    cyc(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
